// File: rtl/video_timing_pattern_gen_if.sv
// video_timing_pattern_gen_if: pattern select inputs and timed pixel outputs of the generator
interface video_timing_pattern_gen_if #(parameter int COLOR_W = 6);
  logic ce;
  logic [2:0] mode;
  logic [COLOR_W-1:0] level;
  logic hs, vs, de, frame_start;
  logic [COLOR_W-1:0] r, g, b;
  logic [11:0] hcount, vcount;
  logic [15:0] frame_cnt;
  modport master (input ce, mode, level, output hs, vs, de, r, g, b, hcount, vcount, frame_start, frame_cnt);
  modport slave (output ce, mode, level, input hs, vs, de, r, g, b, hcount, vcount, frame_start, frame_cnt);
endinterface

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: raster timing with registered sync/de and selectable test patterns
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33,
  parameter int HS_POL = 0, VS_POL = 0, COLOR_W = 6,
  parameter int RAMP_SHIFT = 2, SCROLL_STEP = 6, NOISE_W = 3
) (
  input logic clk,
  input logic reset_n,
  video_timing_pattern_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  logic ce, h_end, v_end, f_end, bar_end, act, hs_on, vs_on;
  logic [11:0] hc_q, hc_d, vc_q, vc_d, bar_px_q, bar_px_d, hcount_q, hcount_d, vcount_q, vcount_d;
  logic [2:0] bar_i_q, bar_i_d, mode_q, mode_d;
  logic [COLOR_W-1:0] level_q, level_d, r_q, r_d, g_q, g_d, b_q, b_d;
  logic [COLOR_W-1:0] ramp, base, noise, grey, pix_r, pix_g, pix_b;
  logic [9:0] scroll_q, scroll_d;
  logic [13:0] vsum;
  logic [22:0] lfsr_q, lfsr_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  assign ce = vif.ce;
  assign h_end = hc_q == H_LAST;
  assign v_end = vc_q == V_LAST;
  assign f_end = h_end && v_end;
  assign bar_end = bar_px_q == BAR_LAST;
  assign act = int'(hc_q) < H_ACTIVE && int'(vc_q) < V_ACTIVE;
  assign hs_on = int'(hc_q) >= H_ACTIVE + H_FP && int'(hc_q) < H_ACTIVE + H_FP + H_SYNC;
  assign vs_on = int'(vc_q) >= V_ACTIVE + V_FP && int'(vc_q) < V_ACTIVE + V_FP + V_SYNC;
  assign ramp = COLOR_W'(hc_q >> RAMP_SHIFT);
  assign vsum = {1'b0, vc_q, 1'b0} + {4'd0, scroll_q};
  assign base = COLOR_W'(vsum >> (11 - COLOR_W));
  assign noise = COLOR_W'(lfsr_q[NOISE_W-1:0]);
  assign grey = base > noise ? base - noise : '0;
  always_comb begin
    pix_r = mode_q == 3'd0 ? level_q : mode_q == 3'd1 ? ramp : mode_q == 3'd2 ? {COLOR_W{~bar_i_q[1]}} : mode_q == 3'd3 ? grey : '0;
    pix_g = mode_q == 3'd0 ? level_q : mode_q == 3'd1 ? ramp : mode_q == 3'd2 ? {COLOR_W{~bar_i_q[2]}} : mode_q == 3'd3 ? grey : '0;
    pix_b = mode_q == 3'd0 ? level_q : mode_q == 3'd1 ? ramp : mode_q == 3'd2 ? {COLOR_W{~bar_i_q[0]}} : mode_q == 3'd3 ? grey : '0;
  end
  always_comb begin
    hc_d = ce ? (h_end ? '0 : hc_q + 12'd1) : hc_q;
    vc_d = ce && h_end ? (v_end ? '0 : vc_q + 12'd1) : vc_q;
    bar_px_d = ce ? (h_end || bar_end ? '0 : bar_px_q + 12'd1) : bar_px_q;
    bar_i_d = ce ? (h_end ? '0 : bar_end && bar_i_q != 3'd7 ? bar_i_q + 3'd1 : bar_i_q) : bar_i_q;
    mode_d = ce && f_end ? vif.mode : mode_q;
    level_d = ce && f_end ? vif.level : level_q;
    scroll_d = ce && f_end ? scroll_q + 10'(SCROLL_STEP) : scroll_q;
    lfsr_d = ce ? {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]} : lfsr_q;
    hs_d = ce ? (hs_on ? HS_ON : ~HS_ON) : hs_q;
    vs_d = ce ? (vs_on ? VS_ON : ~VS_ON) : vs_q;
    de_d = ce ? act : de_q;
    r_d = ce ? (act ? pix_r : '0) : r_q;
    g_d = ce ? (act ? pix_g : '0) : g_q;
    b_d = ce ? (act ? pix_b : '0) : b_q;
    hcount_d = ce ? hc_q : hcount_q;
    vcount_d = ce ? vc_q : vcount_q;
    fs_d = ce && hc_q == '0 && vc_q == '0;
    frame_cnt_d = fs_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q <= '0;
      vc_q <= '0;
      bar_px_q <= '0;
      bar_i_q <= '0;
      mode_q <= '0;
      level_q <= '0;
      scroll_q <= '0;
      lfsr_q <= 23'h1;
      hs_q <= ~HS_ON;
      vs_q <= ~VS_ON;
      de_q <= 1'b0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      fs_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      bar_px_q <= bar_px_d;
      bar_i_q <= bar_i_d;
      mode_q <= mode_d;
      level_q <= level_d;
      scroll_q <= scroll_d;
      lfsr_q <= lfsr_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      fs_q <= fs_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign vif.hs = hs_q;
  assign vif.vs = vs_q;
  assign vif.de = de_q;
  assign vif.r = r_q;
  assign vif.g = g_q;
  assign vif.b = b_q;
  assign vif.hcount = hcount_q;
  assign vif.vcount = vcount_q;
  assign vif.frame_start = fs_q;
  assign vif.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: scoreboard bench for raster timing, patterns, ce gating and reset
module tb_video_timing_pattern_gen;
  typedef struct packed {
    logic hs, vs, de;
    logic [5:0] r, g, b;
    logic [11:0] hc, vc;
    logic fs;
    logic [15:0] fc;
  } out_t;
  localparam out_t RST = {1'b1, 1'b1, 60'd0};
  logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
  always #5 clk = ~clk;
  video_timing_pattern_gen_if #(.COLOR_W(6)) vif_a ();
  video_timing_pattern_gen_if #(.COLOR_W(6)) vif_b ();
  video_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(6), .RAMP_SHIFT(2), .SCROLL_STEP(6), .NOISE_W(3)
  ) u_a (.clk(clk), .reset_n(rst_a), .vif(vif_a));
  video_timing_pattern_gen #(
    .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(6), .RAMP_SHIFT(2), .SCROLL_STEP(6), .NOISE_W(3)
  ) u_b (.clk(clk), .reset_n(rst_b), .vif(vif_b));
  int checks = 0, errors = 0;
  int m_hc, m_vc, m_scroll, de_cnt, vs_cnt, fs_cnt;
  logic [2:0] m_mode;
  logic [5:0] m_level, px8_val;
  logic [22:0] m_lfsr;
  logic bar_chk = 1'b0, px8_en = 1'b0, lfsr_zero = 1'b0;
  out_t m_out;
  out_t q[$];
  always @(negedge clk) if (u_a.lfsr_q == '0 || u_b.lfsr_q == '0) lfsr_zero = 1'b1;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic out_t obs_a();
    return {vif_a.hs, vif_a.vs, vif_a.de, vif_a.r, vif_a.g, vif_a.b, vif_a.hcount, vif_a.vcount, vif_a.frame_start, vif_a.frame_cnt};
  endfunction
  task automatic model_reset();
    m_hc = 0;
    m_vc = 0;
    m_scroll = 0;
    m_mode = 3'd0;
    m_level = 6'd0;
    m_lfsr = 23'h1;
    m_out = RST;
    q.delete();
  endtask
  task automatic model_tick(input logic ce_i, input logic [2:0] mode_i, input logic [5:0] lvl_i);
    out_t e;
    logic act;
    logic [2:0] bi;
    int base, nz, g3;
    logic [5:0] pr, pg, pb;
    e = m_out;
    e.fs = 1'b0;
    if (ce_i) begin
      act = m_hc < 16 && m_vc < 4;
      bi = m_hc / 2 > 7 ? 3'd7 : 3'(m_hc / 2);
      base = ((m_vc * 2 + m_scroll) >> 5) & 63;
      nz = int'(m_lfsr[2:0]);
      g3 = base > nz ? base - nz : 0;
      pr = 6'd0;
      pg = 6'd0;
      pb = 6'd0;
      case (m_mode)
        3'd0: begin pr = m_level; pg = m_level; pb = m_level; end
        3'd1: begin pr = 6'(m_hc >> 2); pg = pr; pb = pr; end
        3'd2: begin pr = {6{~bi[1]}}; pg = {6{~bi[2]}}; pb = {6{~bi[0]}}; end
        3'd3: begin pr = 6'(g3); pg = pr; pb = pr; end
        default: ;
      endcase
      e.hs = !(m_hc >= 18 && m_hc < 20);
      e.vs = m_vc != 5;
      e.de = act;
      e.r = act ? pr : 6'd0;
      e.g = act ? pg : 6'd0;
      e.b = act ? pb : 6'd0;
      e.hc = 12'(m_hc);
      e.vc = 12'(m_vc);
      e.fs = m_hc == 0 && m_vc == 0;
      if (e.fs) e.fc = e.fc + 16'd1;
      m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
      if (m_hc == 21) begin
        m_hc = 0;
        if (m_vc == 6) begin
          m_vc = 0;
          m_mode = mode_i;
          m_level = lvl_i;
          m_scroll = (m_scroll + 6) % 1024;
        end else m_vc++;
      end else m_hc++;
    end
    m_out = e;
    q.push_back(e);
  endtask
  task automatic step(input logic ce_i);
    out_t e, o;
    vif_a.ce = ce_i;
    model_tick(ce_i, vif_a.mode, vif_a.level);
    @(posedge clk);
    #1;
    o = obs_a();
    e = q.pop_front();
    chk("scoreboard", 64'(o), 64'(e));
    de_cnt += int'(o.de);
    vs_cnt += int'(!o.vs);
    fs_cnt += int'(o.fs);
    if (bar_chk && e.vc == 12'd1 && (e.hc < 12'd4 || e.hc > 12'd13))
      chk("bars", 64'({o.r, o.g, o.b}), e.hc < 12'd2 ? 64'h3FFFF : e.hc < 12'd4 ? 64'h3FFC0 : 64'h0);
    if (px8_en && e.hc == 12'd8 && e.vc == 12'd3) chk("px8", 64'({o.r, o.g, o.b}), 64'({3{px8_val}}));
    if (e.vc == 12'd1 && (e.hc == 12'd18 || e.hc == 12'd19)) chk("hsync", 64'(o.hs), 64'd0);
  endtask
  initial begin
    vif_a.ce = 1'b0;
    vif_a.mode = 3'd2;
    vif_a.level = 6'h15;
    vif_b.ce = 1'b1;
    vif_b.mode = 3'd3;
    vif_b.level = 6'd0;
    de_cnt = 0;
    vs_cnt = 0;
    fs_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset", 64'(obs_a()), 64'(RST));
    @(negedge clk) rst_a = 1'b1;
    repeat (154) step(1'b1);
    bar_chk = 1'b1;
    repeat (77) step(1'b1);
    vif_a.mode = 3'd0;
    repeat (77) step(1'b1);
    bar_chk = 1'b0;
    repeat (50) step(1'b1);
    vif_a.mode = 3'd1;
    px8_en = 1'b1;
    px8_val = 6'h15;
    repeat (104) step(1'b1);
    px8_val = 6'd2;
    de_cnt = 0;
    vs_cnt = 0;
    repeat (154) step(1'b1);
    px8_en = 1'b0;
    chk("de_count", 64'(de_cnt), 64'd64);
    chk("vs_count", 64'(vs_cnt), 64'd22);
    vif_a.mode = 3'd3;
    fs_cnt = 0;
    for (int i = 0; i < 308; i++) step(i % 2 == 0);
    chk("fs_count", 64'(fs_cnt), 64'd1);
    repeat (154) step(1'b1);
    for (int n = 0; n < 200 && !(m_out.hc == 12'd5 && m_out.vc == 12'd2); n++) step(1'b1);
    chk("rst_pos", 64'({vif_a.vcount, vif_a.hcount}), 64'({12'd2, 12'd5}));
    #2 rst_a = 1'b0;
    #1 chk("mid_reset", 64'(obs_a()), 64'(RST));
    model_reset();
    vif_a.mode = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_a = 1'b1;
    step(1'b1);
    chk("post_fs", 64'({vif_a.frame_start, vif_a.hcount, vif_a.vcount, vif_a.frame_cnt}), 64'({1'b1, 24'd0, 16'd1}));
    @(negedge clk) rst_b = 1'b1;
    repeat (20500) @(posedge clk);
    #1;
    chk("frame_cnt", 64'(vif_b.frame_cnt), 64'd1025);
    chk("scroll", 64'(u_b.scroll_q), 64'd6);
    chk("lfsr_nz", 64'(lfsr_zero), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
